// File: rtl/phys_reg_tracker.sv
// phys_reg_tracker: physical-register free list and ready list for the R10K
// rename stage, with internal branch checkpoints for single-cycle mispredict
// recovery.
// Optional build macro PHYS_REG_TRACKER_CHECK_EN adds a sticky err output that
// flags double frees, takes while full and restores of invalid slots.
module phys_reg_tracker #(
  parameter int unsigned NUM_PHYS   = 64,
  parameter int unsigned NUM_ARCH   = 32,
  parameter int unsigned ALLOC_W    = 3,
  parameter int unsigned RETIRE_W   = 3,
  parameter int unsigned CDB_W      = 3,
  parameter int unsigned CKPT_DEPTH = 4,
  localparam int unsigned PIDX = $clog2(NUM_PHYS),
  localparam int unsigned CW   = $clog2(ALLOC_W + 1),
  localparam int unsigned RW   = $clog2(RETIRE_W + 1),
  localparam int unsigned KIDX = $clog2(CKPT_DEPTH),
  localparam int unsigned FCW  = $clog2(NUM_PHYS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CW-1:0]                 alloc_req_count,
  output logic [CW-1:0]                 alloc_grant_count,
  output logic [ALLOC_W-1:0][PIDX-1:0]  alloc_idx,
  output logic [FCW-1:0]                free_count,
  input  logic [RW-1:0]                 retire_count,
  input  logic [RETIRE_W-1:0][PIDX-1:0] retire_idx,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W-1:0][PIDX-1:0]    cdb_idx,
  input  logic                          ckpt_take,
  output logic [KIDX-1:0]               ckpt_id,
  output logic                          ckpt_full,
  input  logic                          ckpt_release,
  input  logic [KIDX-1:0]               ckpt_release_id,
  input  logic                          restore,
  input  logic [KIDX-1:0]               restore_id,
  output logic [NUM_PHYS-1:0]           free_list,
  output logic [NUM_PHYS-1:0]           complete_list,
  output logic [NUM_PHYS-1:0]           next_complete_list
`ifdef PHYS_REG_TRACKER_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam logic [NUM_PHYS-1:0] COMPLETE_RST = (NUM_PHYS'(1) << NUM_ARCH) - NUM_PHYS'(1);
  localparam logic [NUM_PHYS-1:0] FREE_RST     = ~COMPLETE_RST;

  logic [NUM_PHYS-1:0]                 free_list_q, free_list_d;
  logic [NUM_PHYS-1:0]                 complete_q;
  logic [FCW-1:0]                      free_count_q, free_count_d;
  logic [CKPT_DEPTH-1:0]               valid_q, valid_d;
  logic [CKPT_DEPTH-1:0][NUM_PHYS-1:0] snap_q, snap_d;
  logic [CKPT_DEPTH-1:0][CKPT_DEPTH-1:0] older_q, older_d;

  logic [NUM_PHYS-1:0]   alloc_mask;
  logic [NUM_PHYS-1:0]   ret_mask;
  logic [NUM_PHYS-1:0]   cdb_mask;
  logic [NUM_PHYS-1:0]   post_alloc;
  logic [CW-1:0]         req_clamp;
  logic                  take_en;
  logic [CKPT_DEPTH-1:0] rel_oh;
  logic [CKPT_DEPTH-1:0] kill;

  // Grant count: clamp request to port width and free count; nothing in restore.
  always_comb begin
    req_clamp = alloc_req_count;
    if (32'(alloc_req_count) > ALLOC_W) req_clamp = CW'(ALLOC_W);
    alloc_grant_count = '0;
    if (!restore) begin
      if (32'(req_clamp) <= 32'(free_count_q)) alloc_grant_count = req_clamp;
      else                                     alloc_grant_count = CW'(free_count_q);
    end
  end

  // Priority selector: the ALLOC_W lowest-indexed free registers.
  always_comb begin
    logic [NUM_PHYS-1:0] avail;
    logic                found;
    avail      = free_list_q;
    alloc_idx  = '0;
    alloc_mask = '0;
    for (int unsigned k = 0; k < ALLOC_W; k++) begin
      found = 1'b0;
      for (int unsigned p = 0; p < NUM_PHYS; p++) begin
        if (!found && avail[p]) begin
          found        = 1'b1;
          avail[p]     = 1'b0;
          alloc_idx[k] = PIDX'(p);
          if (k < 32'(alloc_grant_count)) alloc_mask[p] = 1'b1;
        end
      end
    end
  end

  // Decode retirements and completions into bit masks.
  always_comb begin
    ret_mask = '0;
    cdb_mask = '0;
    for (int unsigned r = 0; r < RETIRE_W; r++) begin
      if (r < 32'(retire_count)) ret_mask[retire_idx[r]] = 1'b1;
    end
    for (int unsigned c = 0; c < CDB_W; c++) begin
      if (cdb_valid[c]) cdb_mask[cdb_idx[c]] = 1'b1;
    end
  end

  // Lowest invalid checkpoint slot and full flag.
  always_comb begin
    logic found;
    found   = 1'b0;
    ckpt_id = '0;
    for (int unsigned s = 0; s < CKPT_DEPTH; s++) begin
      if (!found && !valid_q[s]) begin
        found   = 1'b1;
        ckpt_id = KIDX'(s);
      end
    end
    ckpt_full = &valid_q;
  end

  assign take_en    = ckpt_take && !ckpt_full && !restore;
  assign post_alloc = free_list_q & ~alloc_mask;

  // Allocation clears win over completions on the same index.
  assign next_complete_list = (complete_q | cdb_mask) & ~alloc_mask;

  // Next free list: snapshot on restore, otherwise allocate and free.
  always_comb begin
    free_list_d = post_alloc | ret_mask;
    if (restore) free_list_d = snap_q[restore_id] | ret_mask;
  end

  // Popcount of the next free list, registered alongside it.
  always_comb begin
    free_count_d = '0;
    for (int unsigned p = 0; p < NUM_PHYS; p++) begin
      free_count_d = free_count_d + FCW'(free_list_d[p]);
    end
  end

  // Checkpoint bookkeeping: release, restore squash, take, snapshot refresh.
  always_comb begin
    rel_oh = '0;
    kill   = '0;
    if (ckpt_release && valid_q[ckpt_release_id] &&
        !(restore && (restore_id == ckpt_release_id))) begin
      rel_oh[ckpt_release_id] = 1'b1;
    end
    if (restore) begin
      kill[restore_id] = 1'b1;
      for (int unsigned s = 0; s < CKPT_DEPTH; s++) begin
        if (older_q[s][restore_id]) kill[s] = 1'b1;
      end
    end
    valid_d = valid_q & ~rel_oh & ~kill;
    for (int unsigned s = 0; s < CKPT_DEPTH; s++) begin
      snap_d[s]  = snap_q[s] | ret_mask;
      older_d[s] = older_q[s] & ~rel_oh & ~kill;
    end
    if (take_en) begin
      valid_d[ckpt_id] = 1'b1;
      snap_d[ckpt_id]  = post_alloc | ret_mask;
      older_d[ckpt_id] = valid_q & ~rel_oh;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_list_q  <= FREE_RST;
      complete_q   <= COMPLETE_RST;
      free_count_q <= FCW'(NUM_PHYS - NUM_ARCH);
      valid_q      <= '0;
      snap_q       <= '0;
      older_q      <= '0;
    end else begin
      free_list_q  <= free_list_d;
      complete_q   <= next_complete_list;
      free_count_q <= free_count_d;
      valid_q      <= valid_d;
      snap_q       <= snap_d;
      older_q      <= older_d;
    end
  end

  assign free_list     = free_list_q;
  assign complete_list = complete_q;
  assign free_count    = free_count_q;

`ifdef PHYS_REG_TRACKER_CHECK_EN
  logic err_q, err_d;

  // Sticky protocol-error detection.
  always_comb begin
    err_d = err_q;
    if (ckpt_take && ckpt_full)          err_d = 1'b1;
    if (restore && !valid_q[restore_id]) err_d = 1'b1;
    for (int unsigned r = 0; r < RETIRE_W; r++) begin
      if (r < 32'(retire_count)) begin
        if (free_list_q[retire_idx[r]]) err_d = 1'b1;
        for (int unsigned o = 0; o < r; o++) begin
          if (retire_idx[o] == retire_idx[r]) err_d = 1'b1;
        end
      end
    end
  end

  // Error flag register.
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_phys_reg_tracker.sv
// Self-checking bench for phys_reg_tracker: vector table plus directed
// sequences for allocation limit, restore, nesting, completion and full.
module tb_phys_reg_tracker;

  localparam int unsigned NUM_PHYS = 64;
  localparam int unsigned ALLOC_W  = 3;
  localparam int unsigned RETIRE_W = 3;
  localparam int unsigned CDB_W    = 3;
  localparam int unsigned PIDX     = 6;
  localparam int unsigned CW       = 2;
  localparam int unsigned RW       = 2;
  localparam int unsigned KIDX     = 2;
  localparam int unsigned FCW      = 7;

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic [CW-1:0]                 alloc_req_count;
  logic [CW-1:0]                 alloc_grant_count;
  logic [ALLOC_W-1:0][PIDX-1:0]  alloc_idx;
  logic [FCW-1:0]                free_count;
  logic [RW-1:0]                 retire_count;
  logic [RETIRE_W-1:0][PIDX-1:0] retire_idx;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PIDX-1:0]    cdb_idx;
  logic                          ckpt_take;
  logic [KIDX-1:0]               ckpt_id;
  logic                          ckpt_full;
  logic                          ckpt_release;
  logic [KIDX-1:0]               ckpt_release_id;
  logic                          restore;
  logic [KIDX-1:0]               restore_id;
  logic [NUM_PHYS-1:0]           free_list;
  logic [NUM_PHYS-1:0]           complete_list;
  logic [NUM_PHYS-1:0]           next_complete_list;
`ifdef PHYS_REG_TRACKER_CHECK_EN
  logic                          err;
`endif

  phys_reg_tracker dut (
    .clock              (clock),
    .reset              (reset),
    .alloc_req_count    (alloc_req_count),
    .alloc_grant_count  (alloc_grant_count),
    .alloc_idx          (alloc_idx),
    .free_count         (free_count),
    .retire_count       (retire_count),
    .retire_idx         (retire_idx),
    .cdb_valid          (cdb_valid),
    .cdb_idx            (cdb_idx),
    .ckpt_take          (ckpt_take),
    .ckpt_id            (ckpt_id),
    .ckpt_full          (ckpt_full),
    .ckpt_release       (ckpt_release),
    .ckpt_release_id    (ckpt_release_id),
    .restore            (restore),
    .restore_id         (restore_id),
    .free_list          (free_list),
    .complete_list      (complete_list),
    .next_complete_list (next_complete_list)
`ifdef PHYS_REG_TRACKER_CHECK_EN
    ,
    .err                (err)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CW-1:0]                 req;
    logic [RW-1:0]                 ret_cnt;
    logic [RETIRE_W-1:0][PIDX-1:0] ret;
    logic [CDB_W-1:0]              cdb_v;
    logic [CDB_W-1:0][PIDX-1:0]    cdb;
    logic [CW-1:0]                 exp_grant;
    logic [ALLOC_W-1:0][PIDX-1:0]  exp_idx;
    logic [63:0]                   exp_ncl;
    logic [63:0]                   exp_free;
    logic [FCW-1:0]                exp_cnt;
    logic [63:0]                   exp_cl;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_req_count = '0;
    retire_count    = '0;
    retire_idx      = '0;
    cdb_valid       = '0;
    cdb_idx         = '0;
    ckpt_take       = 1'b0;
    ckpt_release    = 1'b0;
    ckpt_release_id = '0;
    restore         = 1'b0;
    restore_id      = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{req:2'd3, ret_cnt:2'd0, ret:'0, cdb_v:3'b000, cdb:'0,
                exp_grant:2'd3, exp_idx:{6'd34, 6'd33, 6'd32},
                exp_ncl:64'h00000000_FFFFFFFF, exp_free:64'hFFFFFFF8_00000000,
                exp_cnt:7'd29, exp_cl:64'h00000000_FFFFFFFF};
    vecs[1] = '{req:2'd2, ret_cnt:2'd0, ret:'0, cdb_v:3'b011, cdb:{6'd0, 6'd33, 6'd32},
                exp_grant:2'd2, exp_idx:{6'd0, 6'd36, 6'd35},
                exp_ncl:64'h00000003_FFFFFFFF, exp_free:64'hFFFFFFE0_00000000,
                exp_cnt:7'd27, exp_cl:64'h00000003_FFFFFFFF};
    vecs[2] = '{req:2'd0, ret_cnt:2'd2, ret:{6'd0, 6'd7, 6'd5}, cdb_v:3'b000, cdb:'0,
                exp_grant:2'd0, exp_idx:'0,
                exp_ncl:64'h00000003_FFFFFFFF, exp_free:64'hFFFFFFE0_000000A0,
                exp_cnt:7'd29, exp_cl:64'h00000003_FFFFFFFF};
    vecs[3] = '{req:2'd3, ret_cnt:2'd1, ret:{6'd0, 6'd0, 6'd10}, cdb_v:3'b001, cdb:{6'd0, 6'd0, 6'd34},
                exp_grant:2'd3, exp_idx:{6'd37, 6'd7, 6'd5},
                exp_ncl:64'h00000007_FFFFFF5F, exp_free:64'hFFFFFFC0_00000400,
                exp_cnt:7'd27, exp_cl:64'h00000007_FFFFFF5F};
    vecs[4] = '{req:2'd1, ret_cnt:2'd0, ret:'0, cdb_v:3'b100, cdb:{6'd10, 6'd0, 6'd0},
                exp_grant:2'd1, exp_idx:{6'd0, 6'd0, 6'd10},
                exp_ncl:64'h00000007_FFFFFB5F, exp_free:64'hFFFFFFC0_00000000,
                exp_cnt:7'd26, exp_cl:64'h00000007_FFFFFB5F};

    // Reset state
    do_reset();
    chk("reset_free_list", 64'(free_list), 64'hFFFFFFFF_00000000);
    chk("reset_complete_list", 64'(complete_list), 64'h00000000_FFFFFFFF);
    chk("reset_free_count", 64'(free_count), 64'd32);
    chk("reset_ckpt_full", 64'(ckpt_full), 64'd0);
    chk("reset_ckpt_id", 64'(ckpt_id), 64'd0);

    // Vector table from reset
    for (int v = 0; v < 5; v++) begin
      clear_inputs();
      alloc_req_count = vecs[v].req;
      retire_count    = vecs[v].ret_cnt;
      retire_idx      = vecs[v].ret;
      cdb_valid       = vecs[v].cdb_v;
      cdb_idx         = vecs[v].cdb;
      #1;
      chk($sformatf("vec%0d_grant", v), 64'(alloc_grant_count), 64'(vecs[v].exp_grant));
      for (int k = 0; k < ALLOC_W; k++) begin
        if (k < int'(vecs[v].exp_grant))
          chk($sformatf("vec%0d_alloc_idx%0d", v, k), 64'(alloc_idx[k]), 64'(vecs[v].exp_idx[k]));
      end
      chk($sformatf("vec%0d_next_complete", v), 64'(next_complete_list), vecs[v].exp_ncl);
      tick();
      clear_inputs();
      chk($sformatf("vec%0d_free_list", v), 64'(free_list), vecs[v].exp_free);
      chk($sformatf("vec%0d_free_count", v), 64'(free_count), 64'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d_complete_list", v), 64'(complete_list), vecs[v].exp_cl);
    end

    // Allocation limit: drain to P62/P63 only
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      alloc_req_count = 2'd3;
      if (c == 0) begin
        cdb_valid = 3'b011;
        cdb_idx   = {6'd0, 6'd63, 6'd62};
      end
      tick();
    end
    clear_inputs();
    chk("limit_free_list", 64'(free_list), 64'hC0000000_00000000);
    chk("limit_complete_hi", 64'(complete_list[63:62]), 64'd3);
    alloc_req_count = 2'd3;
    #1;
    chk("limit_grant", 64'(alloc_grant_count), 64'd2);
    chk("limit_idx0", 64'(alloc_idx[0]), 64'd62);
    chk("limit_idx1", 64'(alloc_idx[1]), 64'd63);
    tick();
    chk("limit_free_count_zero", 64'(free_count), 64'd0);
    chk("limit_complete_cleared", 64'(complete_list[63:62]), 64'd0);
    #1;
    chk("limit_grant_empty", 64'(alloc_grant_count), 64'd0);

    // Restore with retirement
    do_reset();
    alloc_req_count = 2'd1;
    ckpt_take = 1'b1;
    #1;
    chk("rst_take_id", 64'(ckpt_id), 64'd0);
    chk("rst_alloc32", 64'(alloc_idx[0]), 64'd32);
    tick();
    clear_inputs();
    alloc_req_count = 2'd2;
    retire_count    = 2'd1;
    retire_idx[0]   = 6'd5;
    tick();
    clear_inputs();
    chk("rst_pre_free_list", 64'(free_list), 64'hFFFFFFF8_00000020);
    chk("rst_slot0_taken", 64'(ckpt_id), 64'd1);
    restore = 1'b1;
    restore_id = 2'd0;
    alloc_req_count = 2'd3;
    #1;
    chk("rst_grant_suppressed", 64'(alloc_grant_count), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("rst_free_list", 64'(free_list), 64'hFFFFFFFE_00000020);
    chk("rst_free_count", 64'(free_count), 64'd32);
    chk("rst_slot0_invalid", 64'(ckpt_id), 64'd0);

    // Nested restore, refill and full
    do_reset();
    for (int s = 0; s < 3; s++) begin
      clear_inputs();
      ckpt_take = 1'b1;
      #1;
      chk($sformatf("nest_take%0d_id", s), 64'(ckpt_id), 64'(s));
      tick();
    end
    clear_inputs();
    restore = 1'b1;
    restore_id = 2'd1;
    tick();
    clear_inputs();
    #1;
    chk("nest_after_restore_id", 64'(ckpt_id), 64'd1);
    ckpt_take = 1'b1;
    tick();
    #1;
    chk("nest_next_id", 64'(ckpt_id), 64'd2);
    tick();
    #1;
    chk("nest_next_id3", 64'(ckpt_id), 64'd3);
    chk("nest_not_full", 64'(ckpt_full), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("full_flag", 64'(ckpt_full), 64'd1);
    ckpt_take = 1'b1;
    tick();
    clear_inputs();
    chk("full_still", 64'(ckpt_full), 64'd1);
    ckpt_release = 1'b1;
    ckpt_release_id = 2'd2;
    tick();
    clear_inputs();
    #1;
    chk("release_id", 64'(ckpt_id), 64'd2);
    chk("release_not_full", 64'(ckpt_full), 64'd0);

    // Same-cycle completion wakeup
    do_reset();
    cdb_valid = 3'b101;
    cdb_idx   = {6'd41, 6'd50, 6'd40};
    #1;
    chk("cdb_next_complete", 64'(next_complete_list), 64'h00000300_FFFFFFFF);
    chk("cdb_complete_unchanged", 64'(complete_list), 64'h00000000_FFFFFFFF);
    tick();
    clear_inputs();
    chk("cdb_complete_reg", 64'(complete_list), 64'h00000300_FFFFFFFF);

`ifdef PHYS_REG_TRACKER_CHECK_EN
    // Double free sets sticky err
    do_reset();
    chk("err_reset", 64'(err), 64'd0);
    retire_count  = 2'd1;
    retire_idx[0] = 6'd40;
    tick();
    clear_inputs();
    chk("err_set", 64'(err), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(err), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
